// File: rtl/alu_defs.sv
// Shared ALU definitions: R-type function codes, flag encodings and the
// multi-cycle sequencer state type.
package alu_defs;

    localparam logic [5:0] FUNC_DIV = 6'b000001;
    localparam logic [5:0] FUNC_MUL = 6'b000010;
    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_SUB = 6'b100010;
    localparam logic [5:0] FUNC_AND = 6'b100100;
    localparam logic [5:0] FUNC_OR  = 6'b100101;
    localparam logic [5:0] FUNC_NOT = 6'b100111;
    localparam logic [5:0] FUNC_CMP = 6'b101010;

    localparam logic [2:0] FLAG_NONE      = 3'b000;
    localparam logic [2:0] FLAG_EQUAL     = 3'b001;
    localparam logic [2:0] FLAG_EXCEPTION = 3'b010;
    localparam logic [2:0] FLAG_OVERFLOW  = 3'b011;
    localparam logic [2:0] FLAG_UNDERFLOW = 3'b100;
    localparam logic [2:0] FLAG_ABOVE     = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// Shared accumulator datapath: shift-add multiply and restoring divide, one bit
// per step. The accumulator holds {hi, lo} = {product high, low} or {rem, quot}.
module muldiv_datapath #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     data_a,
    input  logic [WIDTH-1:0]     data_b,
    output logic [2*WIDTH-1:0]   prod_next,
    output logic [WIDTH-1:0]     quot_next
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH-1:0]   rem_next;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (op_b[0] ? {1'b0, op_a} : '0);
        prod_next = {mul_sum, acc[WIDTH-1:1]};
        // Remainder is one bit wider after the shift so the compare never wraps.
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        rem_next  = rem_shift[WIDTH-1:0];
        quot_next = {acc[WIDTH-2:0], 1'b0};
        if (rem_shift >= {1'b0, op_b}) begin
            rem_next  = WIDTH'(rem_shift - {1'b0, op_b});
            quot_next = {acc[WIDTH-2:0], 1'b1};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            op_a <= '0;
            op_b <= '0;
        end else if (load) begin
            acc  <= is_div ? {{WIDTH{1'b0}}, data_a} : '0;
            op_a <= data_a;
            op_b <= data_b;
        end else if (step) begin
            if (is_div) begin
                acc <= {rem_next, quot_next};
            end else begin
                acc  <= prod_next;
                op_b <= op_b >> 1;
            end
        end
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// EX-stage multiply/divide sequencer: FSM, iteration counter, pipeline stall
// and registered result/flag around the shared muldiv datapath.
module ex_muldiv_ctrl
    import alu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flag
);

    state_t               state;
    state_t               next_state;
    logic [CNT_W-1:0]     cnt;
    logic                 accept;
    logic                 load;
    logic                 step;
    logic                 is_div;
    logic                 div_zero;
    logic                 finish_mul;
    logic                 finish_div;
    logic [2*WIDTH-1:0]   prod_next;
    logic [WIDTH-1:0]     quot_next;

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .is_div    (is_div),
        .data_a    (data_a),
        .data_b    (data_b),
        .prod_next (prod_next),
        .quot_next (quot_next)
    );

    always_comb begin
        // Gating with reset keeps stall low for the whole time reset is held.
        accept     = reset && (state == ST_IDLE) && start && !flush &&
                     (func == FUNC_MUL || func == FUNC_DIV);
        div_zero   = (data_b == '0);
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        is_div     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    load   = 1'b1;
                    is_div = (func == FUNC_DIV);
                    if (func == FUNC_MUL) next_state = ST_MUL_RUN;
                    else if (div_zero)    next_state = ST_DONE;
                    else                  next_state = ST_DIV_RUN;
                end
            end
            ST_MUL_RUN, ST_DIV_RUN: begin
                step   = !flush;
                is_div = (state == ST_DIV_RUN);
                if (flush)             next_state = ST_IDLE;
                else if (cnt == '0)    next_state = ST_DONE;
            end
            default: next_state = ST_IDLE;
        endcase
        finish_mul = (state == ST_MUL_RUN) && (next_state == ST_DONE);
        finish_div = (state == ST_DIV_RUN) && (next_state == ST_DONE);
        stall      = accept || (state == ST_MUL_RUN) || (state == ST_DIV_RUN);
        busy       = (state != ST_IDLE);
        done       = (state == ST_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            result <= '0;
            flag   <= FLAG_NONE;
        end else begin
            if (load)      cnt <= CNT_W'(WIDTH - 1);
            else if (step) cnt <= cnt - CNT_W'(1);

            if (load && is_div && div_zero) begin
                result <= '1;
                flag   <= FLAG_EXCEPTION;
            end else if (finish_mul) begin
                result <= prod_next[WIDTH-1:0];
                flag   <= (prod_next[2*WIDTH-1:WIDTH] != '0) ? FLAG_OVERFLOW : FLAG_NONE;
            end else if (finish_div) begin
                result <= quot_next;
                flag   <= FLAG_NONE;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Scoreboard bench for ex_muldiv_ctrl: expected results are queued at issue
// time and compared when done pulses; latency, stall, flush and reset are checked.
module tb_ex_muldiv_ctrl;
    import alu_defs::*;

    localparam int WIDTH = 32;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [2:0]       flag;
    } exp_t;

    logic             clock;
    logic             reset;
    logic             start;
    logic [5:0]       func;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             flush;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [2:0]       flag;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    ex_muldiv_ctrl #(.WIDTH(WIDTH), .CNT_W(5)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .func   (func),
        .data_a (data_a),
        .data_b (data_b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flag   (flag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic issue(input logic [5:0] f, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t        e;
        logic [63:0] p;
        if (f == FUNC_MUL) begin
            p        = {32'b0, a} * {32'b0, b};
            e.result = p[31:0];
            e.flag   = (p[63:32] != 0) ? FLAG_OVERFLOW : FLAG_NONE;
        end else if (b == 0) begin
            e.result = '1;
            e.flag   = FLAG_EXCEPTION;
        end else begin
            e.result = a / b;
            e.flag   = FLAG_NONE;
        end
        exp_q.push_back(e);
        @(negedge clock);
        start  = 1'b1;
        func   = f;
        data_a = a;
        data_b = b;
        #1 check("stall_in_accept", stall, 1);
        @(posedge clock);
        #1;
        start = 1'b0;
        func  = FUNC_ADD;
        check("busy_after_accept", busy, 1);
    endtask

    // Waits for done, counting negedges after the accept edge and stalled cycles.
    // inject_at > 0 drives a competing MUL start on that cycle of the run.
    task automatic wait_done(input string tag, input int exp_lat, input int exp_stall, input int inject_at);
        int   cyc       = 0;
        int   stall_cnt = 1;
        exp_t e;
        do begin
            @(negedge clock);
            cyc++;
            if (cyc == inject_at) begin
                start  = 1'b1;
                func   = FUNC_MUL;
                data_a = 3;
                data_b = 3;
            end else begin
                start = 1'b0;
                func  = FUNC_ADD;
            end
            if (stall) stall_cnt++;
        end while (!done && cyc < 200);
        start = 1'b0;
        check($sformatf("%s_done_seen", tag), done, 1);
        if (done && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("%s_result", tag), result, e.result);
            check($sformatf("%s_flag", tag), flag, e.flag);
            check($sformatf("%s_latency", tag), cyc, exp_lat);
            check($sformatf("%s_stall_cycles", tag), stall_cnt, exp_stall);
            check($sformatf("%s_stall_low_in_done", tag), stall, 0);
        end
        @(posedge clock);
        #1;
        check($sformatf("%s_done_one_cycle", tag), done, 0);
        check($sformatf("%s_idle_after_done", tag), busy, 0);
    endtask

    initial begin
        logic seen_done;
        reset  = 1'b0;
        start  = 1'b1;
        func   = FUNC_MUL;
        data_a = 7;
        data_b = 6;
        flush  = 1'b0;
        #12;
        check("reset_stall", stall, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        check("reset_flag", flag, 0);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b1;

        issue(FUNC_MUL, 7, 6);
        wait_done("mul_7x6", 33, 33, 0);
        issue(FUNC_MUL, 32'h0001_0000, 32'h0001_0000);
        wait_done("mul_ovf", 33, 33, 0);
        issue(FUNC_MUL, 32'hFFFF_FFFF, 1);
        wait_done("mul_ones", 33, 33, 0);
        issue(FUNC_DIV, 100, 7);
        wait_done("div_100_7", 33, 33, 0);
        issue(FUNC_DIV, 5, 0);
        wait_done("div_zero", 1, 1, 0);

        for (int i = 0; i < 3; i++) begin
            issue(FUNC_MUL, $urandom, $urandom);
            wait_done($sformatf("mul_rand%0d", i), 33, 33, 0);
            issue(FUNC_DIV, $urandom, $urandom_range(1, 1000));
            wait_done($sformatf("div_rand%0d", i), 33, 33, 0);
        end

        // Non-muldiv function codes must not engage the sequencer.
        @(negedge clock);
        start = 1'b1;
        func  = FUNC_ADD;
        for (int i = 0; i < 3; i++) begin
            #1 check("add_no_stall", stall, 0);
            @(posedge clock);
            #1;
            check("add_no_busy", busy, 0);
            check("add_no_done", done, 0);
            @(negedge clock);
        end
        start = 1'b0;

        issue(FUNC_MUL, 7, 6);
        wait_done("mul_busy_start", 33, 33, 5);

        issue(FUNC_MUL, 9, 9);
        void'(exp_q.pop_back());
        repeat (9) @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        check("flush_busy", busy, 0);
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clock);
            seen_done |= done;
        end
        check("flush_no_done", seen_done, 0);
        check("flush_result_kept", result, 42);
        check("flush_flag_kept", flag, FLAG_NONE);

        @(negedge clock);
        start  = 1'b1;
        func   = FUNC_MUL;
        data_a = 3;
        data_b = 3;
        flush  = 1'b1;
        #1 check("flush_start_no_stall", stall, 0);
        @(posedge clock);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_no_busy", busy, 0);

        issue(FUNC_DIV, 1000, 3);
        repeat (8) @(negedge clock);
        reset = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_stall", stall, 0);
        check("midrst_result", result, 0);
        check("midrst_flag", flag, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        issue(FUNC_MUL, 3, 3);
        wait_done("mul_after_reset", 33, 33, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
